// File: rtl/regfile_scan.sv
// regfile_scan -- register file with two combinational read ports, one
// synchronous write port and a handshaked serial readout ("dump") engine.
//
// Parameters
//   DATA_W   register width in bits
//   ADDR_W   address width shared by every port
//   NUM_REGS implemented registers (1 .. 2**ADDR_W); higher addresses read 0
//            and ignore writes
//
// Ports
//   clk, rst_n                      clock, asynchronous active-low reset
//   wr_en, wr_addr, wr_data         write port (rising edge)
//   rd_addr_a/b, rd_data_a/b        independent zero-latency read ports
//   dump_req                        start a readout of all registers
//   dump_busy, dump_valid           readout in progress / beat valid
//   dump_ready                      consumer accepts the current beat
//   dump_addr, dump_data            beat index and captured value
//   dump_done                       one-cycle pulse after the last beat
//
// Build option
//   REGFILE_SCAN_BYPASS_EN  when defined, a write is forwarded to the read
//   ports and to the dump capture in the same cycle; otherwise reads and
//   captures see the stored pre-write value.
module regfile_scan #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 3,
  parameter int NUM_REGS = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr_a,
  output logic [DATA_W-1:0] rd_data_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_b,
  input  logic              dump_req,
  output logic              dump_busy,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [ADDR_W-1:0] dump_addr,
  output logic [DATA_W-1:0] dump_data,
  output logic              dump_done
);

  typedef enum logic {IDLE, SCAN} state_e;

  // One extra bit so the range check also works when NUM_REGS == 2**ADDR_W.
  localparam logic [ADDR_W:0]   NUM_REGS_W = (ADDR_W+1)'(NUM_REGS);
  localparam logic [ADDR_W-1:0] LAST_IDX   = ADDR_W'(NUM_REGS - 1);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  // What a reader sees this cycle: stored value, or the in-flight write
  // when forwarding is built in.
  logic [DATA_W-1:0] view   [NUM_REGS];

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d, idx_nxt;
  logic [DATA_W-1:0] dump_data_q, dump_data_d;
  logic              dump_done_q, dump_done_d;
  logic              wr_hit;

  assign wr_hit  = wr_en && ({1'b0, wr_addr} < NUM_REGS_W);
  assign idx_nxt = idx_q + 1'b1;

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      view[i] = regs_q[i];
`ifdef REGFILE_SCAN_BYPASS_EN
      // Gated by rst_n so the read ports stay 0 while reset is held.
      if (rst_n && wr_hit && (wr_addr == ADDR_W'(i))) view[i] = wr_data;
`endif
    end
  end

  assign rd_data_a = ({1'b0, rd_addr_a} < NUM_REGS_W) ? view[rd_addr_a] : '0;
  assign rd_data_b = ({1'b0, rd_addr_b} < NUM_REGS_W) ? view[rd_addr_b] : '0;

  always_comb begin
    regs_d = regs_q;
    if (wr_hit) regs_d[wr_addr] = wr_data;
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    dump_data_d = dump_data_q;
    dump_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        // A request landing in the dump_done cycle is dropped.
        if (dump_req && !dump_done_q) begin
          state_d     = SCAN;
          idx_d       = '0;
          dump_data_d = view[0];
        end
      end
      SCAN: begin
        // dump_valid is always 1 here, so a beat is accepted on dump_ready.
        // While stalled, addr/data hold even if the register is rewritten.
        if (dump_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d     = IDLE;
            idx_d       = '0;
            dump_done_d = 1'b1;
          end else begin
            idx_d       = idx_nxt;
            dump_data_d = view[idx_nxt];
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q      <= '{default: '0};
      state_q     <= IDLE;
      idx_q       <= '0;
      dump_data_q <= '0;
      dump_done_q <= 1'b0;
    end else begin
      regs_q      <= regs_d;
      state_q     <= state_d;
      idx_q       <= idx_d;
      dump_data_q <= dump_data_d;
      dump_done_q <= dump_done_d;
    end
  end

  assign dump_busy  = (state_q == SCAN);
  assign dump_valid = (state_q == SCAN);
  assign dump_addr  = idx_q;
  assign dump_data  = dump_data_q;
  assign dump_done  = dump_done_q;

endmodule

// File: tb/tb_regfile_scan.sv
// Bench for regfile_scan: an 8-register instance and a 6-register instance
// share all inputs and are checked every cycle against a behavioural model
// of the register contents and the readout, plus literal directed checks.
module tb_regfile_scan;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en = 1'b0;
  logic [2:0]  wr_addr = '0;
  logic [15:0] wr_data = '0;
  logic [2:0]  rd_addr_a = '0;
  logic [2:0]  rd_addr_b = '0;
  logic        dump_req = 1'b0;
  logic        dump_ready = 1'b0;

  logic [15:0] rda [2];
  logic [15:0] rdb [2];
  logic [15:0] ddata [2];
  logic [2:0]  daddr [2];
  logic        dbusy [2];
  logic        dvalid [2];
  logic        ddone [2];

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

`ifdef REGFILE_SCAN_BYPASS_EN
  localparam logic [15:0] EXP35 = 16'hAAAA;
`else
  localparam logic [15:0] EXP35 = 16'h0000;
`endif

  always #5 clk = ~clk;

  regfile_scan dut8 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr_a(rd_addr_a), .rd_data_a(rda[0]), .rd_addr_b(rd_addr_b), .rd_data_b(rdb[0]),
    .dump_req(dump_req), .dump_busy(dbusy[0]), .dump_valid(dvalid[0]),
    .dump_ready(dump_ready), .dump_addr(daddr[0]), .dump_data(ddata[0]), .dump_done(ddone[0])
  );

  regfile_scan #(.NUM_REGS(6)) dut6 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr_a(rd_addr_a), .rd_data_a(rda[1]), .rd_addr_b(rd_addr_b), .rd_data_b(rdb[1]),
    .dump_req(dump_req), .dump_busy(dbusy[1]), .dump_valid(dvalid[1]),
    .dump_ready(dump_ready), .dump_addr(daddr[1]), .dump_data(ddata[1]), .dump_done(ddone[1])
  );

  // ---------------- behavioural model ----------------
  logic [15:0] mem [2][8];
  bit          mbusy [2];
  bit          mdone [2];
  int          midx [2];
  logic [15:0] mcap [2];

  logic [15:0] log_d [$];
  logic [2:0]  log_a [$];

  function automatic int nr_of(input int m);
    return (m == 0) ? 8 : 6;
  endfunction

  // Value a reader of register k sees right now in instance m.
  function automatic logic [15:0] vis(input int m, input int k);
    if (k >= nr_of(m)) return 16'h0000;
`ifdef REGFILE_SCAN_BYPASS_EN
    if (rst_n && wr_en && int'(wr_addr) == k) return wr_data;
`endif
    return mem[m][k];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int m = 0; m < 2; m++) begin
        for (int k = 0; k < 8; k++) mem[m][k] <= '0;
        mbusy[m] <= 1'b0;
        mdone[m] <= 1'b0;
        midx[m]  <= 0;
        mcap[m]  <= '0;
      end
    end else begin
      for (int m = 0; m < 2; m++) begin
        mdone[m] <= 1'b0;
        if (!mbusy[m]) begin
          if (dump_req && !mdone[m]) begin
            mbusy[m] <= 1'b1;
            midx[m]  <= 0;
            mcap[m]  <= vis(m, 0);
          end
        end else if (dump_ready) begin
          if (midx[m] == nr_of(m) - 1) begin
            mbusy[m] <= 1'b0;
            mdone[m] <= 1'b1;
            midx[m]  <= 0;
          end else begin
            midx[m] <= midx[m] + 1;
            mcap[m] <= vis(m, midx[m] + 1);
          end
        end
        if (wr_en && int'(wr_addr) < nr_of(m)) mem[m][wr_addr] <= wr_data;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      for (int m = 0; m < 2; m++) begin
        chk($sformatf("rd_a[%0d]", m), 32'(rda[m]), 32'(vis(m, int'(rd_addr_a))));
        chk($sformatf("rd_b[%0d]", m), 32'(rdb[m]), 32'(vis(m, int'(rd_addr_b))));
        chk($sformatf("valid[%0d]", m), 32'(dvalid[m]), 32'(mbusy[m]));
        chk($sformatf("busy[%0d]", m), 32'(dbusy[m]), 32'(mbusy[m]));
        chk($sformatf("done[%0d]", m), 32'(ddone[m]), 32'(mdone[m]));
        if (mbusy[m]) begin
          chk($sformatf("daddr[%0d]", m), 32'(daddr[m]), 32'(midx[m]));
          chk($sformatf("ddata[%0d]", m), 32'(ddata[m]), 32'(mcap[m]));
        end
      end
      if (dvalid[0] && dump_ready) begin
        log_a.push_back(daddr[0]);
        log_d.push_back(ddata[0]);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string nm);
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (ddone[0]) seen = 1'b1;
    end
    chk(nm, 32'(seen), 32'd1);
  endtask

  initial begin
    // Reset values before any clock edge.
    #3;
    for (int m = 0; m < 2; m++) begin
      chk("rst_rda", 32'(rda[m]), 32'h0);
      chk("rst_valid", 32'(dvalid[m]), 32'h0);
      chk("rst_busy", 32'(dbusy[m]), 32'h0);
      chk("rst_done", 32'(ddone[m]), 32'h0);
      chk("rst_daddr", 32'(daddr[m]), 32'h0);
      chk("rst_ddata", 32'(ddata[m]), 32'h0);
    end
    step();
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // Write/read basics.
    step(); wr_en = 1'b1; wr_addr = 3'd2; wr_data = 16'h1234;
    step(); wr_en = 1'b0; rd_addr_a = 3'd2; rd_addr_b = 3'd2;
    @(negedge clk);
    chk("rd_a_2", 32'(rda[0]), 32'h1234);
    chk("rd_b_2", 32'(rdb[0]), 32'h1234);
    step(); rd_addr_a = 3'd3;
    @(negedge clk);
    chk("rd_a_3", 32'(rda[0]), 32'h0000);

    // Same-cycle write then read of reg 1.
    step(); wr_en = 1'b1; wr_addr = 3'd1; wr_data = 16'hAAAA; rd_addr_a = 3'd1;
    @(negedge clk);
    chk("fwd_same_cycle", 32'(rda[0]), 32'(EXP35));
    step(); wr_en = 1'b0;
    @(negedge clk);
    chk("fwd_next_cycle", 32'(rda[0]), 32'hAAAA);

    // Out-of-range write on the 6-register instance.
    step(); wr_en = 1'b1; wr_addr = 3'd7; wr_data = 16'hBEEF;
    step(); wr_en = 1'b0; rd_addr_a = 3'd7;
    @(negedge clk);
    chk("oor_rd7_n6", 32'(rda[1]), 32'h0000);
    chk("oor_rd7_n8", 32'(rda[0]), 32'hBEEF);
    for (int i = 0; i < 6; i++) begin
      step(); rd_addr_a = 3'(i);
      @(negedge clk);
      chk($sformatf("n6_reg%0d", i), 32'(rda[1]),
          (i == 1) ? 32'hAAAA : (i == 2) ? 32'h1234 : 32'h0);
    end

    // Full readout of 0x100+i.
    for (int i = 0; i < 8; i++) begin
      step(); wr_en = 1'b1; wr_addr = 3'(i); wr_data = 16'h0100 + 16'(i);
    end
    step(); wr_en = 1'b0; dump_req = 1'b1; dump_ready = 1'b1;
    step(); dump_req = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk($sformatf("beat%0d_valid", i), 32'(dvalid[0]), 32'h1);
      chk($sformatf("beat%0d_addr", i), 32'(daddr[0]), 32'(i));
      chk($sformatf("beat%0d_data", i), 32'(ddata[0]), 32'h0100 + 32'(i));
    end
    @(negedge clk);
    chk("done_pulse", 32'(ddone[0]), 32'h1);
    chk("done_valid_low", 32'(dvalid[0]), 32'h0);
    @(negedge clk);
    chk("done_one_cycle", 32'(ddone[0]), 32'h0);

    // Stall at beat 3 while reg 3 is rewritten.
    step(); dump_req = 1'b1; dump_ready = 1'b1;
    step(); dump_req = 1'b0;
    step();
    step();
    step(); dump_ready = 1'b0; wr_en = 1'b1; wr_addr = 3'd3; wr_data = 16'hFFFF;
    step(); wr_en = 1'b0;
    step();
    @(negedge clk);
    chk("stall_addr", 32'(daddr[0]), 32'h3);
    chk("stall_data", 32'(ddata[0]), 32'h0103);
    step(); dump_ready = 1'b1;
    wait_done("stall_done_seen");
    step(); log_a.delete(); log_d.delete(); dump_req = 1'b1;
    step(); dump_req = 1'b0;
    wait_done("redump_done_seen");
    chk("redump_beats", 32'(log_d.size()), 32'd8);
    if (log_d.size() == 8) begin
      chk("redump_addr3", 32'(log_a[3]), 32'h3);
      chk("redump_data3", 32'(log_d[3]), 32'hFFFF);
      chk("redump_data0", 32'(log_d[0]), 32'h0100);
    end

    // Reset in the middle of a readout at beat 4.
    step(); dump_req = 1'b1; dump_ready = 1'b1;
    step(); dump_req = 1'b0;
    step();
    step();
    step();
    step(); dump_ready = 1'b0;
    @(negedge clk);
    chk("pre_rst_addr", 32'(daddr[0]), 32'h4);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(dvalid[0]), 32'h0);
    chk("mid_rst_busy", 32'(dbusy[0]), 32'h0);
    chk("mid_rst_daddr", 32'(daddr[0]), 32'h0);
    chk("mid_rst_ddata", 32'(ddata[0]), 32'h0);
    for (int i = 0; i < 8; i++) begin
      step(); rd_addr_a = 3'(i); rd_addr_b = 3'(7 - i);
      @(negedge clk);
      chk($sformatf("rst_reg%0d", i), 32'(rda[0]), 32'h0);
    end
    step(); rst_n = 1'b1; dump_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("no_done_after_rst", 32'(ddone[0]), 32'h0);
    end

    // Randomized traffic checked by the per-cycle compare.
    for (int c = 0; c < 3000; c++) begin
      step();
      wr_en      = 1'($urandom_range(0, 1));
      wr_addr    = 3'($urandom_range(0, 7));
      wr_data    = 16'($urandom);
      rd_addr_a  = 3'($urandom_range(0, 7));
      rd_addr_b  = 3'($urandom_range(0, 7));
      dump_req   = ($urandom_range(0, 7) == 0);
      dump_ready = ($urandom_range(0, 3) != 0);
    end
    step();
    wr_en = 1'b0; dump_req = 1'b0;
    @(negedge clk);
    chk_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/regfile_scan.md
REGFILE_SCAN -- requirements
Module: regfile_scan

Interface
REQ-001 SHALL have parameter DATA_W, default 16, register width in bits.
REQ-002 SHALL have parameter ADDR_W, default 3, address width for all ports.
REQ-003 SHALL have parameter NUM_REGS, default 8, implemented registers, 1 <= NUM_REGS <= 2**ADDR_W.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have ports wr_en input 1, wr_addr input ADDR_W, wr_data input DATA_W  write port.
REQ-007 SHALL have ports rd_addr_a input ADDR_W, rd_data_a output DATA_W  read port A.
REQ-008 SHALL have ports rd_addr_b input ADDR_W, rd_data_b output DATA_W  read port B.
REQ-009 SHALL have port dump_req  input  1  starts a serial readout of all registers.
REQ-010 SHALL have port dump_busy  output  1  high while a readout is in progress.
REQ-011 SHALL have ports dump_valid output 1, dump_ready input 1  readout handshake.
REQ-012 SHALL have ports dump_addr output ADDR_W, dump_data output DATA_W  readout beat index and value.
REQ-013 SHALL have port dump_done  output  1  one-cycle pulse after the last beat is accepted.

Function
REQ-014 Read ports SHALL be combinational, zero latency: rd_data_x = reg[rd_addr_x]; rd_addr_x >= NUM_REGS returns 0.
REQ-015 Write SHALL occur on rising clk when wr_en=1 and wr_addr < NUM_REGS; wr_addr >= NUM_REGS is ignored, no state change.
REQ-016 Both read ports SHALL be independent; same address on A and B returns identical data.
REQ-017 Readout FSM SHALL have states IDLE and SCAN; reset state IDLE.
REQ-018 IDLE -> SCAN on an edge with dump_req=1; index set to 0, dump_data captured from reg[0]; dump_valid=1 from the following cycle.
REQ-019 In SCAN: dump_valid=1, dump_busy=1, dump_addr=index; dump_addr and dump_data SHALL stay stable while dump_valid=1 and dump_ready=0, including when that register is written.
REQ-020 On an edge with dump_valid=1 and dump_ready=1 and index < NUM_REGS-1: index increments by 1 and dump_data recaptures reg[index+1].
REQ-021 On an edge with dump_valid=1 and dump_ready=1 and index = NUM_REGS-1: SCAN -> IDLE; dump_done=1 for exactly the next cycle; dump_valid and dump_busy drop to 0.
REQ-022 Captured value SHALL be the pre-edge stored register value; a write to the same register on the capture edge is not included (see REQ-031).
REQ-023 dump_req SHALL be ignored while in SCAN and in the dump_done cycle; it is honoured again from the first cycle IDLE with dump_done=0.
REQ-024 Normal writes and reads SHALL proceed unaffected during SCAN.
REQ-025 NUM_REGS=1: one beat at dump_addr 0, then dump_done.

Reset
REQ-026 rst_n=0 SHALL immediately, without clk, clear all registers to 0, FSM to IDLE, index to 0.
REQ-027 Output values during and after reset: rd_data_a=rd_data_b=0; dump_busy, dump_valid and dump_done 0; dump_addr 0; dump_data 0.
REQ-028 Reset assertion mid-SCAN SHALL abort the readout; no dump_done pulse is generated.

Configuration
REQ-029 Macro REGFILE_SCAN_BYPASS_EN SHALL select write-to-read forwarding.
REQ-030 Defined: when wr_en=1 and wr_addr=rd_addr_x < NUM_REGS, rd_data_x = wr_data in the same cycle.
REQ-031 Defined: a same-edge write to the register being captured SHALL be included in the captured dump_data.
REQ-032 Undefined: reads and captures return the stored pre-write value; the new value is visible from the next cycle.

Verification
REQ-033 Reset, write 0x1234 to addr 2, then read A=2, B=2 -> both 0x1234; read addr 3 -> 0x0000 (defaults).
REQ-034 With NUM_REGS=6, write 0xBEEF to addr 7 -> ignored; reading addr 7 -> 0; all registers 0 to 5 unchanged.
REQ-035 wr_en=1, wr_addr=1, wr_data=0xAAAA, rd_addr_a=1 in the same cycle -> 0xAAAA with macro defined, old value 0x0000 without.
REQ-036 Load reg[i]=0x100+i, pulse dump_req with dump_ready=1 -> beats addr 0..7 with data 0x100..0x107 on consecutive cycles, then dump_done high for one cycle.
REQ-037 During SCAN, hold dump_ready=0 at addr 3 and write 0xFFFF to reg 3 -> dump_data stays 0x103; after release, the next readout shows 0xFFFF.
REQ-038 Assert rst_n=0 at addr 4 of a readout -> dump_valid=0 and dump_busy=0 immediately, all registers 0, no dump_done pulse.
